// File: rtl/pe_conv_multichannel.sv
// Multichannel convolution processing element.
// Holds CHANNELS pairs of KxK picture/filter buffers, accumulates the sum of
// all per-channel dot products, then shifts, saturates (optional ReLU in
// signed mode) and offers the result on a valid/ready handshake.
//
// state | meaning
// IDLE  | buffers writable/shiftable, waiting for start
// RUN   | one element per channel accumulated per cycle, row-major
// SUM   | scale and saturate accumulator into data_out
// OUT   | result presented, waiting for out_ready
module pe_conv_multichannel #(
  parameter int KERNEL_SIZE = 4,
  parameter int CHANNELS    = 2,
  parameter int DATA_W      = 8,
  parameter int SIGNED      = 0,
  parameter int IDX_W       = 32,
  parameter int ACC_W       = 2*DATA_W + $clog2(KERNEL_SIZE*KERNEL_SIZE*CHANNELS) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pic_wr_en,
  input  logic [CHANNELS-1:0]          fil_wr_en,
  input  logic                         shift_up,
  input  logic                         shift_left,
  input  logic [IDX_W-1:0]             idx_i,
  input  logic [IDX_W-1:0]             idx_j,
  input  logic [CHANNELS*DATA_W-1:0]   buf_data_in,
  input  logic [DATA_W-1:0]            fil_data_in,
  input  logic [$clog2(ACC_W)-1:0]     out_shift,
  input  logic                         relu_en,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            data_out,
  output logic                         done
);

  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int EW   = (KK > 1) ? $clog2(KK) : 1;
  localparam int SH_W = $clog2(ACC_W);

  localparam logic [ACC_W-1:0] U_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic [ACC_W-1:0] S_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, SUM, OUT} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   pic [CHANNELS][KK];
  logic [DATA_W-1:0]   fil [CHANNELS][KK];
  logic [EW-1:0]       cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    term_sum;
  logic [ACC_W-1:0]    scaled;
  logic [DATA_W-1:0]   sat_res;
  logic [SH_W-1:0]     shift_q;
  logic                relu_q;
  logic                wr_ok;
  logic [EW-1:0]       wr_e;

  // Extension to accumulator width; the low ACC_W bits of the product are
  // identical for signed and unsigned operands once extended correctly.
  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    else             return {{(ACC_W-DATA_W){1'b0}}, v};
  endfunction

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign done      = out_valid && out_ready;

  assign wr_ok = (idx_i < IDX_W'(KERNEL_SIZE)) && (idx_j < IDX_W'(KERNEL_SIZE));
  assign wr_e  = EW'(idx_i * IDX_W'(KERNEL_SIZE) + idx_j);

  // Sum of this cycle's products over all channels at element cnt.
  always_comb begin
    term_sum = '0;
    for (int n = 0; n < CHANNELS; n++)
      term_sum = term_sum + ext(fil[n][cnt]) * ext(pic[n][cnt]);
  end

  // Scale, saturate and optionally ReLU the accumulator.
  always_comb begin
    if (SIGNED != 0) scaled = $unsigned($signed(acc) >>> shift_q);
    else             scaled = acc >> shift_q;
    sat_res = scaled[DATA_W-1:0];
    if (SIGNED != 0) begin
      if ($signed(scaled) > $signed(S_MAX))      sat_res = S_MAX[DATA_W-1:0];
      else if ($signed(scaled) < $signed(S_MIN)) sat_res = S_MIN[DATA_W-1:0];
      if (relu_q && scaled[ACC_W-1])             sat_res = '0;
    end else if (scaled > U_MAX) begin
      sat_res = U_MAX[DATA_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == EW'(KK-1)) state_nxt = SUM;
      SUM:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, element counter, latched controls and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      cnt      <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc     <= '0;
          cnt     <= '0;
          shift_q <= out_shift;
          relu_q  <= relu_en;
        end
        RUN: begin
          acc <= acc + term_sum;
          cnt <= cnt + 1'b1;
        end
        SUM:     data_out <= sat_res;
        default: ;
      endcase
    end
  end

  // Buffer writes and shifts, only while idle; a picture write blocks shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < CHANNELS; n++)
        for (int e = 0; e < KK; e++) begin
          pic[n][e] <= '0;
          fil[n][e] <= '0;
        end
    end else if (state == IDLE) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (pic_wr_en) begin
          if (wr_ok) pic[n][wr_e] <= buf_data_in[n*DATA_W +: DATA_W];
        end else if (shift_up) begin
          for (int e = 0; e < KK; e++)
            pic[n][e] <= (e < KK - KERNEL_SIZE) ? pic[n][(e + KERNEL_SIZE) % KK] : '0;
        end else if (shift_left) begin
          for (int e = 0; e < KK; e++)
            pic[n][e] <= ((e % KERNEL_SIZE) != KERNEL_SIZE - 1) ? pic[n][(e + 1) % KK] : '0;
        end
        if (fil_wr_en[n] && wr_ok) fil[n][wr_e] <= fil_data_in;
      end
    end
  end

endmodule

// File: doc/pe_conv_multichannel.md
Name: pe_conv_multichannel

Overview:
- Next-generation convolution processing element.
- Holds CH channel pairs of KxK picture-window and filter buffers, and computes the sum over all channels of the KxK dot products.
- Scales the sum by a runtime right-shift, then saturates it (optional ReLU in signed mode).
- Delivers the result over a valid/ready handshake. It sits between the window-fetch logic and the output-map writer in the convolution datapath.

Parameters:
KERNEL_SIZE, 4, kernel/window edge K (K>=2)
CHANNELS, 2, number of channel pairs CH (CH>=1)
DATA_W, 8, element and output width DW
SIGNED, 0, 0 = unsigned arithmetic; 1 = two's-complement arithmetic with ReLU option
IDX_W, 32, width of write index ports
ACC_W, 2*DATA_W+$clog2(KERNEL_SIZE*KERNEL_SIZE*CHANNELS)+1, accumulator width (never overflows)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous and active-low (0 = reset)
start  in  1  begin computation; sampled only in IDLE
pic_wr_en  in  1  write buf_data_in into all picture buffers at (idx_i, idx_j)
fil_wr_en  in  CHANNELS  per-channel filter write enable at (idx_i, idx_j)
shift_up  in  1  every picture buffer: row r <= row r+1, last row <= 0
shift_left  in  1  every picture buffer: col c <= col c+1, last col <= 0
idx_i  in  IDX_W  write row index
idx_j  in  IDX_W  write column index
buf_data_in  in  CHANNELS*DATA_W  picture data; channel n occupies bits [n*DW +: DW]
fil_data_in  in  DATA_W  filter data shared by all channels
out_shift  in  $clog2(ACC_W)  right-shift amount; sampled with start
relu_en  in  1  clamp negative results to 0 (SIGNED=1 only); sampled with start
busy  out  1  high whenever state != IDLE
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
data_out  out  DATA_W  scaled, saturated result
done  out  1  high exactly on the handshake cycle (out_valid && out_ready)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, accumulator=0, all buffers=0.
  - busy=0, out_valid=0, data_out=0, done=0.
  - Applies from any state, including mid-RUN and mid-OUT. Operation resumes on the first edge after rst returns to 1.
- FSM states: IDLE, RUN, SUM, OUT.
  - IDLE -> RUN on start. On that edge E0: accumulator cleared, out_shift and relu_en latched, element counter=0.
  - RUN: one product per channel per cycle, visited row-major (0,0),(0,1)...(K-1,K-1). On each edge, acc += sum over channels of fil[n][r][c]*pic[n][r][c].
  - RUN -> SUM on the edge that adds element K*K-1, i.e. edge E0+K*K.
  - SUM: on edge E0+K*K+1, compute the scaled result into the data_out register and go to OUT (out_valid=1). Latency from the start edge to out_valid is K*K+1 edges.
  - OUT: data_out and out_valid hold stable while out_ready=0. On an edge with out_ready=1: go to IDLE, out_valid=0, data_out keeps its value.
  - start outside IDLE is ignored (no queuing). start on the same edge that leaves OUT is also ignored.
- Buffer writes and shifts are honoured only in IDLE; outside IDLE they are dropped.
  - Priority within one cycle: write > shift_up > shift_left.
  - Writes with idx_i>=K or idx_j>=K are ignored.
  - pic_wr_en together with fil_wr_en writes both at the same index.
- Arithmetic:
  - Products and accumulation are unsigned, or signed when SIGNED=1 (operands sign-extended).
  - Scaling is a logical right shift (unsigned) or arithmetic right shift (signed) by the latched out_shift.
  - Saturation: unsigned clamps to [0, 2^DW-1]; signed clamps to [-2^(DW-1), 2^(DW-1)-1].
  - ReLU (SIGNED=1 and latched relu_en=1) forces negative values to 0 after saturation. relu_en has no effect when SIGNED=0.

Test Plan:
- K=2, CH=2, DW=8, unsigned: all filters=1, all pixels=3, out_shift=0, out_ready=1 -> out_valid rises 5 edges after start, data_out=24, done high for 1 cycle, busy low the next cycle.
- Same config, all filters and pixels=255: out_shift=11 -> data_out=254 (520200>>11); out_shift=0 -> data_out=255 (saturated).
- Backpressure: hold out_ready=0 for 6 cycles after out_valid -> data_out and out_valid stable, done=0; raise out_ready -> done=1 for one cycle, then IDLE. A start pulsed during OUT is ignored (busy stays high, no second result).
- SIGNED=1, channel 0 filter all 0xFF (-1) and pixels 5, channel 1 filter all 0 -> sum -20. relu_en=0 gives data_out=0xEC; relu_en=1 gives data_out=0x00.
- Shift/priority: load picture row-major with values 1..4 (K=2) and pulse shift_up -> rows become {3,4},{0,0}. Assert pic_wr_en and shift_left together -> only the write takes effect. A write with idx_i=2 leaves all buffers unchanged.
- Reset: drive rst=0 during RUN -> busy=0, out_valid=0, data_out=0 with no clock edge needed. After release, the buffers read 0 and a fresh start gives data_out=0.
